// File: rtl/traffic_pkg.sv
// Shared phase codes and FSM state encoding for the traffic phase scheduler
// and the light control unit.
// Optional macro: TRAFFIC_NIGHT_FLASH_EN adds the FLASH state.
package traffic_pkg;

  localparam logic [1:0] CODE_NONE   = 2'b00;
  localparam logic [1:0] CODE_RED    = 2'b01;
  localparam logic [1:0] CODE_GREEN  = 2'b10;
  localparam logic [1:0] CODE_YELLOW = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RED    = 3'd1,
    ST_GREEN  = 3'd2,
`ifdef TRAFFIC_NIGHT_FLASH_EN
    ST_FLASH  = 3'd4,
`endif
    ST_YELLOW = 3'd3
  } state_t;

  // Steady-state phase code for a state (FLASH is handled by the caller).
  function automatic logic [1:0] code_of(state_t s);
    case (s)
      ST_RED:    code_of = CODE_RED;
      ST_GREEN:  code_of = CODE_GREEN;
      ST_YELLOW: code_of = CODE_YELLOW;
      default:   code_of = CODE_NONE;
    endcase
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Shared tick prescaler: counts 0..TICK_DIV-1 while enabled and pulses tick
// in the cycle the count wraps.
// Ports: clk, reset (async, active-high), enable, tick (combinational pulse).
module tick_prescaler #(
  parameter int unsigned TICK_DIV = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  localparam int unsigned    CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0]  LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] r_cnt;
  logic          w_wrap;

  assign w_wrap = (r_cnt == LAST);
  // Gated by reset so tick stays low while reset is held, even for TICK_DIV=1.
  assign tick   = enable & w_wrap & ~reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       r_cnt <= '0;
    else if (enable) r_cnt <= w_wrap ? '0 : r_cnt + CW'(1);
  end

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Timed Red -> Green -> Yellow sequencer with pedestrian Green truncation.
// Ports: clk, reset (async, active-high), enable, ped_btn, night_mode (only
// with TRAFFIC_NIGHT_FLASH_EN), sw_traffic_lights[1:0] (registered phase
// code), ped_pending (registered), tick (prescaler pulse).
// Optional macro: TRAFFIC_NIGHT_FLASH_EN enables the night flash mode.
module traffic_phase_scheduler
  import traffic_pkg::*;
#(
  parameter int unsigned TICK_DIV        = 1000,
  parameter int unsigned CNT_W           = 16,
  parameter int unsigned RED_TICKS       = 50,
  parameter int unsigned GREEN_TICKS     = 80,
  parameter int unsigned YELLOW_TICKS    = 20,
  parameter int unsigned MIN_GREEN_TICKS = 30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       ped_btn,
`ifdef TRAFFIC_NIGHT_FLASH_EN
  input  logic       night_mode,
`endif
  output logic [1:0] sw_traffic_lights,
  output logic       ped_pending,
  output logic       tick
);

  localparam int unsigned RED_EFF    = (RED_TICKS    == 0) ? 1 : RED_TICKS;
  localparam int unsigned GREEN_EFF  = (GREEN_TICKS  == 0) ? 1 : GREEN_TICKS;
  localparam int unsigned YELLOW_EFF = (YELLOW_TICKS == 0) ? 1 : YELLOW_TICKS;
  localparam logic [CNT_W-1:0] RED_LOAD    = CNT_W'(RED_EFF - 1);
  localparam logic [CNT_W-1:0] GREEN_LOAD  = CNT_W'(GREEN_EFF - 1);
  localparam logic [CNT_W-1:0] YELLOW_LOAD = CNT_W'(YELLOW_EFF - 1);

  state_t           r_state, w_state_next;
  logic [CNT_W-1:0] r_dwell, w_dwell_next;
  logic [1:0]       r_code,  w_code_next;
  logic             r_ped_pending, w_ped_next;
  logic             r_btn_q;
  logic             w_tick, w_rise, w_enter_red, w_ped_cut;
`ifdef TRAFFIC_NIGHT_FLASH_EN
  logic             r_flash_on, w_flash_next;
`endif

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .tick   (w_tick)
  );

  assign tick              = w_tick;
  assign sw_traffic_lights = r_code;
  assign ped_pending       = r_ped_pending;
  assign w_rise            = ped_btn & ~r_btn_q;
  assign w_enter_red       = (w_state_next == ST_RED) && (r_state != ST_RED);
  // The current tick is the MIN_GREEN_TICKS-th (or later) Green tick.
  assign w_ped_cut = r_ped_pending &&
                     ((32'(r_dwell) + MIN_GREEN_TICKS) <= GREEN_EFF);

  // Next-state, dwell and code logic.
  always_comb begin
    w_state_next = r_state;
    w_dwell_next = r_dwell;
`ifdef TRAFFIC_NIGHT_FLASH_EN
    w_flash_next = r_flash_on;
`endif
    case (r_state)
      ST_IDLE: begin
        if (enable) begin
          w_state_next = ST_RED;
          w_dwell_next = RED_LOAD;
        end
      end
      ST_RED: begin
        if (w_tick) begin
          if (r_dwell == '0) begin
            w_state_next = ST_GREEN;
            w_dwell_next = GREEN_LOAD;
          end else w_dwell_next = r_dwell - CNT_W'(1);
        end
      end
      ST_GREEN: begin
        if (w_tick) begin
          if (r_dwell == '0 || w_ped_cut) begin
            w_state_next = ST_YELLOW;
            w_dwell_next = YELLOW_LOAD;
          end else w_dwell_next = r_dwell - CNT_W'(1);
        end
      end
      ST_YELLOW: begin
        if (w_tick) begin
          if (r_dwell == '0) begin
            w_state_next = ST_RED;
            w_dwell_next = RED_LOAD;
          end else w_dwell_next = r_dwell - CNT_W'(1);
        end
      end
`ifdef TRAFFIC_NIGHT_FLASH_EN
      ST_FLASH: begin
        if (w_tick) begin
          if (night_mode) w_flash_next = ~r_flash_on;
          else begin
            w_state_next = ST_RED;
            w_dwell_next = RED_LOAD;
          end
        end
      end
`endif
      default: w_state_next = ST_IDLE;
    endcase

`ifdef TRAFFIC_NIGHT_FLASH_EN
    // Night request overrides normal sequencing from any running phase.
    if (w_tick && night_mode &&
        (r_state == ST_RED || r_state == ST_GREEN || r_state == ST_YELLOW)) begin
      w_state_next = ST_FLASH;
      w_flash_next = 1'b1;
    end
    if (w_state_next == ST_FLASH)
      w_code_next = w_flash_next ? CODE_YELLOW : CODE_NONE;
    else
      w_code_next = code_of(w_state_next);
`else
    w_code_next = code_of(w_state_next);
`endif

    // A new press beats the clear on Red entry so it is served next Green.
    if (w_rise)           w_ped_next = 1'b1;
    else if (w_enter_red) w_ped_next = 1'b0;
    else                  w_ped_next = r_ped_pending;
  end

  // State register; the button edge register runs even while disabled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_dwell       <= '0;
      r_code        <= CODE_NONE;
      r_ped_pending <= 1'b0;
      r_btn_q       <= 1'b0;
`ifdef TRAFFIC_NIGHT_FLASH_EN
      r_flash_on    <= 1'b0;
`endif
    end else begin
      r_state       <= w_state_next;
      r_dwell       <= w_dwell_next;
      r_code        <= w_code_next;
      r_ped_pending <= w_ped_next;
      r_btn_q       <= ped_btn;
`ifdef TRAFFIC_NIGHT_FLASH_EN
      r_flash_on    <= w_flash_next;
`endif
    end
  end

endmodule
